// File: rtl/bus_control_sequencer_if.sv
// Bus-control interface for the Mini SRC control sequencer.
// Groups the instruction/memory-status inputs with every control strobe the
// sequencer drives into the datapath.
//   ir       : instruction register contents (op, Ra, Rb, Rc fields)
//   mem_rdy  : memory read data valid
//   stop     : halt request
//   bus_sel  : one-hot bus source select (R0..R15, HI, LO, Zhigh, Zlow, PC, MDR, InPort, C)
//   r_in     : one-hot register-file load enable
//   pc_in .. lo_in : single-bit load/strobe enables
//   alu_op   : ALU function, meaningful while z_in=1
//   running  : sequencer is executing (not in RST/HALT)
//   err      : sticky memory-timeout flag
//   state    : debug view of the sequencer state
// Modports: master = the sequencer, slave = the datapath / environment.
interface bus_control_sequencer_if;
    logic [31:0] ir;
    logic        mem_rdy;
    logic        stop;
    logic [23:0] bus_sel;
    logic [15:0] r_in;
    logic        pc_in;
    logic        inc_pc;
    logic        mar_in;
    logic        mdr_in;
    logic        mem_rd;
    logic        ir_in;
    logic        y_in;
    logic        z_in;
    logic        hi_in;
    logic        lo_in;
    logic [4:0]  alu_op;
    logic        running;
    logic        err;
    logic [3:0]  state;

    modport master (
        input  ir, mem_rdy, stop,
        output bus_sel, r_in, pc_in, inc_pc, mar_in, mdr_in, mem_rd, ir_in,
               y_in, z_in, hi_in, lo_in, alu_op, running, err, state
    );

    modport slave (
        output ir, mem_rdy, stop,
        input  bus_sel, r_in, pc_in, inc_pc, mar_in, mdr_in, mem_rd, ir_in,
               y_in, z_in, hi_in, lo_in, alu_op, running, err, state
    );
endinterface

// File: rtl/bus_control_sequencer.sv
// Moore control sequencer for the single shared 32-bit bus of the Mini SRC CPU.
// Fetches an instruction (T0-T2), decodes it in T3 and executes R-type ALU,
// immediate ALU and mul/div instructions in T4-T6; nop and halt finish in T3.
// Ports:
//   clock : rising-edge clock
//   clear : asynchronous active-high reset
//   bus   : bus_control_sequencer_if.master (instruction/memory inputs, control outputs)
// Parameter MEM_TIMEOUT: number of T1 cycles allowed without mem_rdy before
// the sequencer halts with err set.
module bus_control_sequencer #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                      clock,
    input  logic                      clear,
    bus_control_sequencer_if.master   bus
);

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_t;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_HALT = 5'd27;
    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state, state_next;
    logic [7:0] t1_cnt;
    logic       err_q;
    logic [4:0] op_q;
    logic [3:0] ra_q, rc_q;

    logic [4:0] ir_op;
    logic [3:0] ir_ra, ir_rb, ir_rc;
    logic       unused_ir;
    logic       t1_expire;

    logic [23:0] bus_sel;
    logic [15:0] r_in;
    logic        pc_in, inc_pc, mar_in, mdr_in, mem_rd, ir_in, y_in, z_in, hi_in, lo_in;
    logic [4:0]  alu_op;

    assign ir_op     = bus.ir[31:27];
    assign ir_ra     = bus.ir[26:23];
    assign ir_rb     = bus.ir[22:19];
    assign ir_rc     = bus.ir[18:15];
    assign unused_ir = ^bus.ir[14:0];

    // Last allowed T1 cycle without data: leave for HALT instead of waiting again.
    assign t1_expire = (state == S_T1) && !bus.mem_rdy && (t1_cnt == TMO_LAST);

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state  <= S_RST;
            t1_cnt <= '0;
            err_q  <= 1'b0;
            op_q   <= '0;
            ra_q   <= '0;
            rc_q   <= '0;
        end else begin
            state <= state_next;
            // Counts T1 cycles of the current fetch; zero outside T1.
            if (state == S_T1) t1_cnt <= t1_cnt + 8'd1;
            else               t1_cnt <= '0;
            if (t1_expire) err_q <= 1'b1;
            // The fields are captured at the end of T3 so T4-T6 do not depend on ir.
            if (state == S_T3) begin
                op_q <= ir_op;
                ra_q <= ir_ra;
                rc_q <= ir_rc;
            end
        end
    end

    always_comb begin
        state_next = state;
        bus_sel    = '0;
        r_in       = '0;
        pc_in      = 1'b0;
        inc_pc     = 1'b0;
        mar_in     = 1'b0;
        mdr_in     = 1'b0;
        mem_rd     = 1'b0;
        ir_in      = 1'b0;
        y_in       = 1'b0;
        z_in       = 1'b0;
        hi_in      = 1'b0;
        lo_in      = 1'b0;
        alu_op     = '0;
        case (state)
            S_RST: state_next = S_T0;
            S_T0: begin
                // MAR <- PC and Z <- PC + 1 in the same cycle.
                bus_sel[20] = 1'b1;
                mar_in      = 1'b1;
                inc_pc      = 1'b1;
                z_in        = 1'b1;
                alu_op      = OP_ADD;
                state_next  = bus.stop ? S_HALT : S_T1;
            end
            S_T1: begin
                bus_sel[19] = 1'b1;
                pc_in       = (t1_cnt == 8'd0);
                mem_rd      = 1'b1;
                mdr_in      = 1'b1;
                if (bus.mem_rdy)    state_next = S_T2;
                else if (t1_expire) state_next = S_HALT;
            end
            S_T2: begin
                bus_sel[21] = 1'b1;
                ir_in       = 1'b1;
                state_next  = S_T3;
            end
            S_T3: begin
                if (ir_op <= 5'd16) begin
                    bus_sel[ir_rb] = 1'b1;
                    y_in           = 1'b1;
                    state_next     = S_T4;
                end else if (ir_op == OP_HALT) begin
                    state_next = S_HALT;
                end else begin
                    state_next = S_T0;
                end
            end
            S_T4: begin
                z_in   = 1'b1;
                alu_op = op_q;
                // Immediate forms take the C constant instead of Rc.
                if (op_q >= 5'd12 && op_q <= 5'd14) bus_sel[23]   = 1'b1;
                else                                 bus_sel[rc_q] = 1'b1;
                state_next = S_T5;
            end
            S_T5: begin
                bus_sel[19] = 1'b1;
                if (op_q <= 5'd14) begin
                    r_in[ra_q] = 1'b1;
                    state_next = S_T0;
                end else begin
                    lo_in      = 1'b1;
                    state_next = S_T6;
                end
            end
            S_T6: begin
                bus_sel[18] = 1'b1;
                hi_in       = 1'b1;
                state_next  = S_T0;
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_RST;
        endcase
    end

    assign bus.bus_sel = bus_sel;
    assign bus.r_in    = r_in;
    assign bus.pc_in   = pc_in;
    assign bus.inc_pc  = inc_pc;
    assign bus.mar_in  = mar_in;
    assign bus.mdr_in  = mdr_in;
    assign bus.mem_rd  = mem_rd;
    assign bus.ir_in   = ir_in;
    assign bus.y_in    = y_in;
    assign bus.z_in    = z_in;
    assign bus.hi_in   = hi_in;
    assign bus.lo_in   = lo_in;
    assign bus.alu_op  = alu_op;
    assign bus.running = (state != S_RST) && (state != S_HALT);
    assign bus.err     = err_q;
    assign bus.state   = state;

endmodule

// File: tb/tb_bus_control_sequencer.sv
// Testbench for bus_control_sequencer. Builds the expected per-cycle control
// word of every instruction from its op class, register fields and memory wait
// count, and compares it against the DUT each cycle.
module tb_bus_control_sequencer;
    localparam int TMO = 4;
    localparam int W   = 57;

    localparam logic [9:0] F_PC  = 10'h200;
    localparam logic [9:0] F_INC = 10'h100;
    localparam logic [9:0] F_MAR = 10'h080;
    localparam logic [9:0] F_MDR = 10'h040;
    localparam logic [9:0] F_RD  = 10'h020;
    localparam logic [9:0] F_IR  = 10'h010;
    localparam logic [9:0] F_Y   = 10'h008;
    localparam logic [9:0] F_Z   = 10'h004;
    localparam logic [9:0] F_HI  = 10'h002;
    localparam logic [9:0] F_LO  = 10'h001;

    logic clock = 1'b0;
    logic clear = 1'b1;
    int   checks = 0;
    int   passes = 0;
    logic [W-1:0] exp_q[$];

    bus_control_sequencer_if bus ();

    bus_control_sequencer #(.MEM_TIMEOUT(TMO)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    // ---------------- model helpers ----------------
    function automatic logic [W-1:0] pk(input int bsel, input int rsel, input logic [9:0] fl,
                                        input logic [4:0] aop, input logic run, input logic e);
        logic [23:0] b;
        logic [15:0] r;
        b = '0;
        r = '0;
        if (bsel >= 0) b[bsel] = 1'b1;
        if (rsel >= 0) r[rsel] = 1'b1;
        return {b, r, fl, aop, run, e};
    endfunction

    function automatic logic [W-1:0] actual();
        return {bus.bus_sel, bus.r_in, bus.pc_in, bus.inc_pc, bus.mar_in, bus.mdr_in,
                bus.mem_rd, bus.ir_in, bus.y_in, bus.z_in, bus.hi_in, bus.lo_in,
                bus.alu_op, bus.running, bus.err};
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic lit_chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- scoreboard / compare ----------------
    always @(negedge clock) begin
        logic [W-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("cycle", actual(), e);
            lit_chk("onehot0", {31'd0, $onehot0(bus.bus_sel) && $onehot0(bus.r_in)}, 32'd1);
        end
    end

    // ---------------- driver ----------------
    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic step(input logic clr, input logic [31:0] irv, input logic rdy,
                        input logic stp, input logic [W-1:0] e);
        @(posedge clock);
        #1;
        clear       = clr;
        bus.ir      = irv;
        bus.mem_rdy = rdy;
        bus.stop    = stp;
        exp_q.push_back(e);
    endtask

    task automatic do_halt(input logic e, input logic lit);
        step(1'b0, $urandom, rbit(), rbit(), pk(-1, -1, 10'h0, 5'd0, 1'b0, e));
        if (lit) begin
            #3;
            lit_chk("halt_run_err", {30'd0, bus.running, bus.err}, {30'd0, 1'b0, e});
        end
        step(1'b0, $urandom, rbit(), rbit(), pk(-1, -1, 10'h0, 5'd0, 1'b0, e));
        step(1'b1, $urandom, rbit(), rbit(), '0);
        step(1'b0, $urandom, rbit(), rbit(), '0);
    endtask

    task automatic run_instr(input logic [4:0] op, input logic [3:0] ra, input logic [3:0] rb,
                             input logic [3:0] rc, input int waits, input logic stop0,
                             input logic abort_t4, input logic lit);
        logic [31:0] irv;
        logic [14:0] low;
        low = 15'($urandom);
        irv = {op, ra, rb, rc, low};
        // T0
        step(1'b0, $urandom, rbit(), stop0, pk(20, -1, F_MAR | F_INC | F_Z, 5'd0, 1'b1, 1'b0));
        if (lit) begin
            #3;
            lit_chk("t0_bus_sel", {8'd0, bus.bus_sel}, 32'h0010_0000);
        end
        if (stop0) begin
            do_halt(1'b0, lit);
            return;
        end
        // T1: waits cycles without data, then one with data, unless it times out
        if (waits >= TMO) begin
            for (int i = 0; i < TMO; i++)
                step(1'b0, $urandom, 1'b0, rbit(),
                     pk(19, -1, ((i == 0) ? F_PC : 10'h0) | F_RD | F_MDR, 5'd0, 1'b1, 1'b0));
            do_halt(1'b1, lit);
            return;
        end
        for (int i = 0; i <= waits; i++)
            step(1'b0, $urandom, (i == waits), rbit(),
                 pk(19, -1, ((i == 0) ? F_PC : 10'h0) | F_RD | F_MDR, 5'd0, 1'b1, 1'b0));
        // T2
        step(1'b0, $urandom, rbit(), rbit(), pk(21, -1, F_IR, 5'd0, 1'b1, 1'b0));
        // T3
        if (op <= 5'd16) begin
            step(1'b0, irv, rbit(), rbit(), pk(int'(rb), -1, F_Y, 5'd0, 1'b1, 1'b0));
            if (lit) begin
                #3;
                lit_chk("t3_bus_sel", {8'd0, bus.bus_sel}, 32'd1 << rb);
            end
        end else begin
            step(1'b0, irv, rbit(), rbit(), pk(-1, -1, 10'h0, 5'd0, 1'b1, 1'b0));
            if (op == 5'd27) do_halt(1'b0, lit);
            return;
        end
        // T4
        step(1'b0, $urandom, rbit(), rbit(),
             pk((op >= 5'd12 && op <= 5'd14) ? 23 : int'(rc), -1, F_Z, op, 1'b1, 1'b0));
        if (abort_t4) begin
            #2;
            clear = 1'b1;
            #1;
            check("abort_t4", actual(), '0);
            void'(exp_q.pop_back());
            exp_q.push_back('0);
            step(1'b0, $urandom, rbit(), rbit(), '0);
            return;
        end
        // T5 / T6
        if (op <= 5'd14) begin
            step(1'b0, $urandom, rbit(), rbit(), pk(19, int'(ra), 10'h0, 5'd0, 1'b1, 1'b0));
            if (lit) begin
                #3;
                lit_chk("t5_r_in", {bus.bus_sel[15:0], bus.r_in}, {16'h0000, 16'd1 << ra});
            end
        end else begin
            step(1'b0, $urandom, rbit(), rbit(), pk(19, -1, F_LO, 5'd0, 1'b1, 1'b0));
            step(1'b0, $urandom, rbit(), rbit(), pk(18, -1, F_HI, 5'd0, 1'b1, 1'b0));
            if (lit) begin
                #3;
                lit_chk("t6_hi", {7'd0, bus.hi_in, bus.bus_sel}, 32'h0104_0000);
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [4:0] op;
        int         kind;
        int         waits;
        bus.ir      = '0;
        bus.mem_rdy = 1'b0;
        bus.stop    = 1'b0;

        // Reset held, then released: one RST cycle before T0.
        step(1'b1, $urandom, rbit(), rbit(), '0);
        step(1'b1, $urandom, rbit(), rbit(), '0);
        step(1'b0, $urandom, rbit(), rbit(), '0);

        // Directed cases
        run_instr(5'd0,  4'd3, 4'd1, 4'd2, 0, 1'b0, 1'b0, 1'b1);   // add R3,R1,R2
        run_instr(5'd3,  4'd5, 4'd5, 4'd5, 3, 1'b0, 1'b0, 1'b0);   // 3 wait cycles, Rb=Rc=Ra
        run_instr(5'd15, 4'd1, 4'd1, 4'd2, 0, 1'b0, 1'b0, 1'b1);   // mul
        run_instr(5'd13, 4'd0, 4'd7, 4'd9, 1, 1'b0, 1'b0, 1'b1);   // ori into R0
        run_instr(5'd4,  4'd2, 4'd6, 4'd8, 0, 1'b0, 1'b1, 1'b0);   // clear mid-T4
        run_instr(5'd16, 4'd9, 4'd3, 4'd4, TMO - 1, 1'b0, 1'b0, 1'b0);
        run_instr(5'd1,  4'd1, 4'd2, 4'd3, TMO, 1'b0, 1'b0, 1'b1); // memory timeout
        run_instr(5'd26, 4'd0, 4'd0, 4'd0, 0, 1'b0, 1'b0, 1'b0);   // nop
        run_instr(5'd31, 4'd4, 4'd4, 4'd4, 1, 1'b0, 1'b0, 1'b0);   // undefined op
        run_instr(5'd27, 4'd0, 4'd0, 4'd0, 0, 1'b0, 1'b0, 1'b1);   // halt
        run_instr(5'd2,  4'd1, 4'd2, 4'd3, 0, 1'b1, 1'b0, 1'b1);   // stop in T0

        // Randomized instruction stream
        for (int n = 0; n < 250; n++) begin
            kind = $urandom_range(0, 9);
            case (kind)
                0, 1, 2, 3: op = 5'($urandom_range(0, 11));
                4:          op = 5'($urandom_range(12, 14));
                5:          op = 5'($urandom_range(15, 16));
                6:          op = 5'd26;
                7:          op = ($urandom_range(0, 3) == 0) ? 5'd27 : 5'($urandom_range(0, 16));
                8:          op = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(17, 25))
                                                              : 5'($urandom_range(28, 31));
                default:    op = 5'($urandom_range(0, 31));
            endcase
            waits = ($urandom_range(0, 9) == 0) ? $urandom_range(0, TMO + 2) : $urandom_range(0, 2);
            run_instr(op, 4'($urandom), 4'($urandom), 4'($urandom), waits,
                      ($urandom_range(0, 19) == 0), ($urandom_range(0, 24) == 0), 1'b0);
        end

        @(negedge clock);
        #1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
